// File: rtl/all_gates.sv
// Registered bitwise gate bank: AND/OR/NOT/NAND/NOR/XOR/XNOR of two WIDTH-bit operands, 1-cycle latency.
// Optional accepted-pair counter on sample_cnt when ALL_GATES_COUNT_EN is defined.
module all_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] not_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o,
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] xnor_o
`ifdef ALL_GATES_COUNT_EN
  ,
  output logic [15:0]      sample_cnt
`endif
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Result and valid registers; inverted results are stored separately so they reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      and_o     <= ZERO_W;
      or_o      <= ZERO_W;
      not_o     <= ZERO_W;
      nand_o    <= ZERO_W;
      nor_o     <= ZERO_W;
      xor_o     <= ZERO_W;
      xnor_o    <= ZERO_W;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        and_o  <= a & b;
        or_o   <= a | b;
        not_o  <= ~a;
        nand_o <= ~(a & b);
        nor_o  <= ~(a | b);
        xor_o  <= a ^ b;
        xnor_o <= ~(a ^ b);
      end
    end
  end

`ifdef ALL_GATES_COUNT_EN
  // Saturating count of accepted operand pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= 16'h0000;
    end else if (in_valid && (sample_cnt != 16'hFFFF)) begin
      sample_cnt <= sample_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_all_gates.sv
// Self-checking bench for all_gates: WIDTH=8 and WIDTH=1 instances against a behavioural model.
// Counter checks are included when ALL_GATES_COUNT_EN is defined.
module tb_all_gates;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic       a1, b1;

  logic       ov8, ov1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
  logic       and1, or1, not1, nand1, nor1, xor1, xnor1;
`ifdef ALL_GATES_COUNT_EN
  logic [15:0] cnt8, cnt1;
`endif

  int checks;
  int failures;

  // model state
  logic [7:0]  e8 [7];
  logic [7:0]  e1 [7];
  logic        ev;
  logic [15:0] ecnt;

  all_gates #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov8), .and_o(and8), .or_o(or8), .not_o(not8), .nand_o(nand8),
    .nor_o(nor8), .xor_o(xor8), .xnor_o(xnor8)
`ifdef ALL_GATES_COUNT_EN
    , .sample_cnt(cnt8)
`endif
  );

  all_gates #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov1), .and_o(and1), .or_o(or1), .not_o(not1), .nand_o(nand1),
    .nor_o(nor1), .xor_o(xor1), .xnor_o(xnor1)
`ifdef ALL_GATES_COUNT_EN
    , .sample_cnt(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gate(int op, logic [7:0] x, logic [7:0] y);
    case (op)
      0: return x & y;
      1: return x | y;
      2: return ~x;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return x ^ y;
      6: return ~(x ^ y);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] obs8(int op);
    case (op)
      0: return and8;
      1: return or8;
      2: return not8;
      3: return nand8;
      4: return nor8;
      5: return xor8;
      6: return xnor8;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] obs1(int op);
    case (op)
      0: return {7'd0, and1};
      1: return {7'd0, or1};
      2: return {7'd0, not1};
      3: return {7'd0, nand1};
      4: return {7'd0, nor1};
      5: return {7'd0, xor1};
      6: return {7'd0, xnor1};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge: update model from the inputs applied, then move to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 7; k++) begin
        e8[k] = 8'h00;
        e1[k] = 8'h00;
      end
      ev   = 1'b0;
      ecnt = 16'h0000;
    end else begin
      ev = in_valid;
      if (in_valid) begin
        for (int k = 0; k < 7; k++) begin
          e8[k] = gate(k, a8, b8);
          e1[k] = gate(k, {7'd0, a1}, {7'd0, b1}) & 8'h01;
        end
        if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s_w8_op%0d", tag, k), {56'd0, obs8(k)}, {56'd0, e8[k]});
      chk($sformatf("%s_w1_op%0d", tag, k), {56'd0, obs1(k)}, {56'd0, e1[k]});
    end
    chk({tag, "_ov8"}, {63'd0, ov8}, {63'd0, ev});
    chk({tag, "_ov1"}, {63'd0, ov1}, {63'd0, ev});
`ifdef ALL_GATES_COUNT_EN
    chk({tag, "_cnt8"}, {48'd0, cnt8}, {48'd0, ecnt});
    chk({tag, "_cnt1"}, {48'd0, cnt1}, {48'd0, ecnt});
`endif
  endtask

  logic [6:0] truth [4];
  logic [1:0] ab;

  initial begin
    checks   = 0;
    failures = 0;
    ev       = 1'b0;
    ecnt     = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      e8[k] = 8'h00;
      e1[k] = 8'h00;
    end
    // {and,or,not,nand,nor,xor,xnor} for a/b = 00,01,10,11
    truth[0] = 7'b0011101;
    truth[1] = 7'b0111010;
    truth[2] = 7'b0101010;
    truth[3] = 7'b1100001;

    rst = 1'b1; in_valid = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    // reset with valid traffic present: everything cleared, pair discarded
    tick();
    check_all("reset");
    chk("reset_and1_const", {63'd0, and1}, 64'd0);
    chk("reset_ov1_const", {63'd0, ov1}, 64'd0);

    // WIDTH=1 truth table on consecutive cycles
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      a8 = {4'h0, 2'b00, ab}; b8 = ~a8;
      tick();
      check_all($sformatf("truth%0d", i));
      chk($sformatf("truth%0d_const", i),
          {57'd0, and1, or1, not1, nand1, nor1, xor1, xnor1}, {57'd0, truth[i]});
      chk($sformatf("truth%0d_ov_const", i), {63'd0, ov1}, 64'd1);
    end

    // WIDTH=8 directed vector
    a8 = 8'hF0; b8 = 8'h3C; a1 = 1'b0; b1 = 1'b1;
    tick();
    check_all("w8vec");
    chk("w8vec_const", {8'd0, and8, or8, not8, nand8, nor8, xor8, xnor8},
        {8'd0, 8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33});

    // hold: accept a=1,b=0 then idle while toggling operands
    a8 = 8'h01; b8 = 8'h00; a1 = 1'b1; b1 = 1'b0;
    tick();
    check_all("hold_load");
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); a1 = ~a1; b1 = ~b1;
      tick();
      check_all($sformatf("hold%0d", i));
      chk($sformatf("hold%0d_const", i), {60'd0, or1, xor1, not1, ov1}, {60'd0, 4'b1100});
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      tick();
      check_all($sformatf("rand%0d", i));
    end

`ifdef ALL_GATES_COUNT_EN
    // counter saturation then clear
    rst = 1'b1; in_valid = 1'b1;
    tick();
    check_all("cnt_reset");
    rst = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      tick();
      if (i == 65534 || i == 65535 || i == 69999) check_all($sformatf("cnt%0d", i));
    end
    chk("cnt_sat_const", {48'd0, cnt8}, {48'd0, 16'hFFFF});
    rst = 1'b1;
    tick();
    check_all("cnt_clear");
    chk("cnt_clear_const", {48'd0, cnt1}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
